and5_reduce_seq: RTL and testbench
==================================

# and5_reduce_seq

Sequencer that feeds the project's cell-based 5-bit bitwise-AND stage. It accepts a frame of N 5-bit words over a valid/ready stream and applies each word with the running accumulator to the AND stage. It registers the AND output back into the accumulator and reports the frame's AND-reduction with a one-cycle `done` pulse. It sits between the operand source and the result consumer, so the AND stage is only ever driven from registered values.

## Interface
- `CNT_W`, default 4: width of the frame-length input; maximum frame is 2^CNT_W−1 words.
- `clk`, input, 1: the block's single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: begins a frame when sampled high in IDLE; ignored in every other state.
- `count`, input, CNT_W: number of words in the frame; sampled only together with an accepted `start`.
- `din`, input, 5: operand word.
- `din_valid`, input, 1: `din` is valid this cycle.
- `din_ready`, output, 1: the block accepts `din` this cycle.
- `result`, output, 5: AND of all words in the last completed frame; held until the next frame completes.
- `done`, output, 1: one-cycle pulse; `result` is updated in the same cycle.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- Internal registers:
  - `acc[4:0]`.
  - `remaining[CNT_W-1:0]`.
  - `result_q[4:0]`, which drives `result`.
  - State register with states IDLE, ACC, FIN.
- Datapath:
  - The AND-stage inputs are `a = acc` and `b = din`.
  - The AND-stage output `acc & din` is the next `acc` on every accepted word.
  - No other logic is allowed between the stage output and `acc`.
- IDLE:
  - `din_ready = 0`, `busy = 0`.
  - On `start` with `count != 0`: `acc <= 5'b11111`, `remaining <= count`, go to ACC.
  - On `start` with `count == 0`: `acc <= 5'b11111`, go directly to FIN, so the empty frame yields `11111`.
- ACC:
  - `din_ready = 1`, `busy = 1`.
  - A word is accepted when `din_valid && din_ready`. On acceptance: `acc <= acc & din`, `remaining <= remaining − 1`.
  - If the accepted word arrives while `remaining == 1`, go to FIN.
  - Cycles with `din_valid = 0` are stalls; all state is held.
- FIN:
  - `din_ready = 0`, `busy = 1`.
  - `result_q <= acc`, `done` is high for this one cycle, go to IDLE.
- Early zero: if `acc` reaches `00000` before the frame ends, the block still consumes all remaining words. Frame alignment with the source is mandatory.
- `start` asserted in ACC or FIN is ignored and not queued.
- `count` and `din` are don't-care outside their sampling conditions.
- `remaining` never underflows. It is only decremented in ACC, and ACC is left when it equals 1.

## Timing
- Reset values: state IDLE, `acc = 5'b11111`, `remaining = 0`, `result = 5'b00000`, `done = 0`, `din_ready = 0`, `busy = 0`.
- Reset mid-frame:
  - The partial frame is discarded.
  - `result` returns to `00000` immediately, since reset is asynchronous.
  - No `done` pulse is produced.
  - The first `start` after reset deassertion begins a clean frame.
- Flow:
  - `start` is accepted at edge T0.
  - `din_ready` is high from T0+ onward.
  - With `din_valid` held high, words are accepted on edges T1..TN.
  - FIN runs in the cycle after edge TN.
  - `done` and the new `result` are visible after edge TN+1.
  - Total latency: N+2 cycles from `start` to `done`. For `count == 0`, `done` appears 2 cycles after `start`.
- Throughput:
  - One word per cycle while `din_valid` is held high.
  - Minimum gap between frames: `start` can be accepted in the cycle after `done` (IDLE). Back-to-back frames therefore cost N+2 cycles each.
- `din_ready` depends only on state, never combinationally on `din_valid`.
- `done` is high for exactly one cycle per frame and never high in the cycle after reset deassertion.

## Test plan
- Reset, then `start` with `count=3` and words `11111`, `10110`, `00111` with `din_valid` held high. Required: `din_ready` high for 3 cycles, `done` one cycle later, `result=00110`, `busy` low the next cycle.
- `count=4` with `din_valid` toggled 1,0,1,0,1,0,1 and words `11110`, `11101`, `11011`, `10111`. Required: exactly 4 accepts, `result=10000`, `done` 8 cycles after the first word is presented.
- `count=0`. Required: `done` 2 cycles after `start`, `result=11111`, `din_ready` never high.
- `start` pulsed during ACC of a `count=2` frame (`01010`, `01100`). Required: the pulse is ignored, a single `done`, `result=01000`.
- Early zero, `count=3` with `10101`, `01010`, `11111`. Required: the third word is still consumed, `result=00000`.
- `rst` asserted mid-frame after 2 of 5 words, then a new `count=1` frame with `00011`. Required: `result=00000` during reset, no stray `done`, then `result=00011` after the new frame.

Source files
------------

// File: rtl/and5_reduce_seq_if.sv
// rtl/and5_reduce_seq_if.sv - operand/result stream bundle for the 5-bit AND-reduce sequencer
interface and5_reduce_seq_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic [4:0]       din;
    logic             din_valid;
    logic             din_ready;
    logic [4:0]       result;
    logic             done;
    logic             busy;

    modport master (
        output start, count, din, din_valid,
        input  din_ready, result, done, busy
    );

    modport slave (
        input  start, count, din, din_valid,
        output din_ready, result, done, busy
    );
endinterface

// File: rtl/and5_reduce_seq.sv
// rtl/and5_reduce_seq.sv - frame sequencer driving a cell-based 5-bit AND stage from registered operands
module and5_stage (
    input  logic [4:0] a_i,
    input  logic [4:0] b_i,
    output logic [4:0] y_o
);
    for (genvar i = 0; i < 5; i++) begin : g_cell
        assign y_o[i] = a_i[i] & b_i[i];
    end
endmodule

module and5_reduce_seq #(
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    and5_reduce_seq_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [4:0]       result_q, result_d;
    logic             done_q, done_d;
    logic [4:0]       stage_y;

    // Stage output feeds acc_d directly; nothing else sits on that path.
    and5_stage u_stage (
        .a_i (acc_q),
        .b_i (bus.din),
        .y_o (stage_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= 5'b11111;
            rem_q    <= '0;
            result_q <= 5'b00000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = 5'b11111;
                    if (bus.count != '0) begin
                        rem_d   = bus.count;
                        state_d = ACC;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            ACC: begin
                if (bus.din_valid) begin
                    acc_d = stage_y;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready comes from state only so the source never sees a combinational loop.
    assign bus.din_ready = (state_q == ACC);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_and5_reduce_seq.sv
// tb/tb_and5_reduce_seq.sv - table-driven bench for and5_reduce_seq
module tb_and5_reduce_seq;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    and5_reduce_seq_if #(.CNT_W(4)) bus ();

    and5_reduce_seq #(.CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       cnt;
        logic [15:0][4:0] w;
        bit               toggle;
        bit               spur;
        logic [4:0]       exp;
        int               lat;
        int               rdy;
    } vec_t;

    vec_t tbl [7];
    vec_t after_rst;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Caller is at a falling edge; start is raised in the current cycle.
    task automatic run_frame(input vec_t v, input string tag);
        int k;
        int idx;
        int rdy;
        bit seen;
        bit vld;
        k = 0; idx = 0; rdy = 0; seen = 1'b0;
        bus.start     = 1'b1;
        bus.count     = v.cnt;
        bus.din_valid = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            bus.start = v.spur && (k == 1);
            bus.count = (v.spur && k == 1) ? 4'd1 : 4'($urandom);
            if (bus.done) begin
                seen          = 1'b1;
                bus.din_valid = 1'b0;
            end else if (bus.din_ready) begin
                rdy++;
                vld           = !v.toggle || (rdy % 2 == 1);
                bus.din_valid = vld;
                bus.din       = (vld && idx < 16) ? v.w[idx] : 5'($urandom);
                if (vld) idx++;
            end else begin
                bus.din_valid = 1'($urandom);
                bus.din       = 5'($urandom);
            end
        end
        chk($sformatf("%s done_seen", tag), int'(seen), 1);
        chk($sformatf("%s latency", tag), k, v.lat);
        chk($sformatf("%s result", tag), int'(bus.result), int'(v.exp));
        chk($sformatf("%s accepts", tag), idx, int'(v.cnt));
        chk($sformatf("%s ready_cycles", tag), rdy, v.rdy);
        chk($sformatf("%s busy_at_done", tag), int'(bus.busy), 0);
        chk($sformatf("%s ready_at_done", tag), int'(bus.din_ready), 0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        // Words are listed last-first: w[0] is the first word of the frame.
        tbl[0] = '{cnt: 4'd3, w: 80'({5'b00111, 5'b10110, 5'b11111}),
                   toggle: 1'b0, spur: 1'b0, exp: 5'b00110, lat: 5, rdy: 3};
        tbl[1] = '{cnt: 4'd4, w: 80'({5'b10111, 5'b11011, 5'b11101, 5'b11110}),
                   toggle: 1'b1, spur: 1'b0, exp: 5'b10000, lat: 9, rdy: 7};
        tbl[2] = '{cnt: 4'd0, w: 80'(0),
                   toggle: 1'b0, spur: 1'b0, exp: 5'b11111, lat: 2, rdy: 0};
        tbl[3] = '{cnt: 4'd2, w: 80'({5'b01100, 5'b01010}),
                   toggle: 1'b0, spur: 1'b1, exp: 5'b01000, lat: 4, rdy: 2};
        tbl[4] = '{cnt: 4'd3, w: 80'({5'b11111, 5'b01010, 5'b10101}),
                   toggle: 1'b0, spur: 1'b0, exp: 5'b00000, lat: 5, rdy: 3};
        tbl[5] = '{cnt: 4'd15, w: 80'({5'b01111, {14{5'b11111}}}),
                   toggle: 1'b0, spur: 1'b0, exp: 5'b01111, lat: 17, rdy: 15};
        tbl[6] = '{cnt: 4'd1, w: 80'(5'b11001),
                   toggle: 1'b0, spur: 1'b0, exp: 5'b11001, lat: 3, rdy: 1};
        after_rst = '{cnt: 4'd1, w: 80'(5'b00011),
                   toggle: 1'b0, spur: 1'b0, exp: 5'b00011, lat: 3, rdy: 1};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.count     = '0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset result", int'(bus.result), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset ready", int'(bus.din_ready), 0);
        chk("reset busy", int'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset done", int'(bus.done), 0);
        chk("post_reset busy", int'(bus.busy), 0);

        // Each frame starts in the done cycle of the previous one (minimum gap).
        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i], $sformatf("vec%0d", i));
        end

        bus.start = 1'b0;
        @(negedge clk);
        chk("idle done_low", int'(bus.done), 0);
        chk("idle result_held", int'(bus.result), 5'b11001);
        chk("idle busy", int'(bus.busy), 0);

        bus.start = 1'b1;
        bus.count = 4'd5;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.din_valid = 1'b1;
        bus.din       = 5'b11100;
        @(negedge clk);
        bus.din = 5'b00111;
        @(negedge clk);
        bus.din_valid = 1'b0;
        chk("midframe busy", int'(bus.busy), 1);
        chk("midframe ready", int'(bus.din_ready), 1);
        rst = 1'b1;
        #1;
        chk("async_rst result", int'(bus.result), 0);
        chk("async_rst busy", int'(bus.busy), 0);
        chk("async_rst ready", int'(bus.din_ready), 0);
        chk("async_rst done", int'(bus.done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("after_rst done%0d", i), int'(bus.done), 0);
            chk($sformatf("after_rst busy%0d", i), int'(bus.busy), 0);
        end
        run_frame(after_rst, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
